// File: rtl/text_pkg.sv
// Shared constants and FSM encoding for the character text buffer.
package text_pkg;

   localparam logic [7:0] CHAR_SPACE = 8'h20;
   localparam logic [7:0] CHAR_LF    = 8'h0A;
   localparam logic [7:0] CHAR_FF    = 8'h0C;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCROLL = 2'd1,
      ST_CLEAR  = 2'd2
   } state_e;

endpackage

// File: rtl/text_buffer_ram.sv
// Character storage: one write port, a registered read-before-write read
// port and a combinational source port used while scrolling.
module text_buffer_ram
   import text_pkg::*;
#(
   parameter int DEPTH     = 32,
   parameter int ADDR_W    = 5,
   parameter int CHAR_W    = 8,
   parameter int INIT_BASE = 48
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [CHAR_W-1:0] i_wr_data,
   input  logic              i_rd_en,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [CHAR_W-1:0] o_rd_data,
   input  logic [ADDR_W-1:0] i_src_addr,
   output logic [CHAR_W-1:0] o_src_data
);

   logic [CHAR_W-1:0] cell_w [DEPTH];
   logic [CHAR_W-1:0] rd_q;

   for (genvar g = 0; g < DEPTH; g++) begin : g_cell
      // Power-on content is the linear index offset by INIT_BASE.
      logic [CHAR_W-1:0] cell_q = CHAR_W'(INIT_BASE + g);

      // NOTE: storage cells take no reset; only writes change them, so the
      // power-on pattern survives i_rst and the array can map onto RAM/LUTs.
      always_ff @(posedge i_clk) begin
         if (i_wr_en && (i_wr_addr == ADDR_W'(g))) begin
            cell_q <= i_wr_data;
         end
      end

      assign cell_w[g] = cell_q;
   end

   // Registered read; sees the cell value from before a same-edge write.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rd_q <= '0;
      end else begin
         rd_q <= i_rd_en ? cell_w[i_rd_addr] : CHAR_W'(CHAR_SPACE);
      end
   end

   assign o_rd_data  = rd_q;
   assign o_src_data = ({1'b0, i_src_addr} < (ADDR_W + 1)'(DEPTH))
                       ? cell_w[i_src_addr] : CHAR_W'(CHAR_SPACE);

endmodule

// File: rtl/text_buffer.sv
// Character text buffer with write cursor, line feed, scroll and clear.
module text_buffer
   import text_pkg::*;
#(
   parameter int COLS      = 16,
   parameter int ROWS      = 2,
   parameter int CHAR_W    = 8,
   parameter int INIT_BASE = 48
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_wrValid,
   output logic                    o_wrReady,
   input  logic [CHAR_W-1:0]       i_wrData,
   input  logic [$clog2(ROWS)-1:0] i_rdRow,
   input  logic [$clog2(COLS)-1:0] i_rdCol,
   output logic [CHAR_W-1:0]       o_rdData,
   output logic [$clog2(ROWS)-1:0] o_cursorRow,
   output logic [$clog2(COLS)-1:0] o_cursorCol,
   output logic                    o_busy
);

   localparam int ROW_W  = $clog2(ROWS);
   localparam int COL_W  = $clog2(COLS);
   localparam int DEPTH  = ROWS * COLS;
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int COPY_N = (ROWS - 1) * COLS;

   localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(ROWS - 1);
   localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
   localparam logic [ADDR_W-1:0] SEQ_LAST = ADDR_W'(DEPTH - 1);

   state_e             state_q, state_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic [COL_W-1:0]   col_q, col_d;
   logic [ADDR_W-1:0]  seq_q, seq_d;

   logic               wr_en;
   logic [ADDR_W-1:0]  wr_addr;
   logic [CHAR_W-1:0]  wr_data;
   logic               rd_en;
   logic [ADDR_W-1:0]  rd_addr;
   logic [ADDR_W-1:0]  src_addr;
   logic [CHAR_W-1:0]  src_data;

   function automatic logic [ADDR_W-1:0] lin_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
      return ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
   endfunction

   assign rd_en    = ({1'b0, i_rdRow} < (ROW_W + 1)'(ROWS)) &&
                     ({1'b0, i_rdCol} < (COL_W + 1)'(COLS));
   assign rd_addr  = lin_addr(i_rdRow, i_rdCol);
   assign src_addr = seq_q + ADDR_W'(COLS);

   // Next-state, cursor movement and write-port control.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      seq_d   = seq_q;
      wr_en   = 1'b0;
      wr_addr = lin_addr(row_q, col_q);
      wr_data = i_wrData;

      case (state_q)
         ST_IDLE: begin
            if (i_wrValid) begin
               if (i_wrData == CHAR_W'(CHAR_FF)) begin
                  state_d = ST_CLEAR;
                  seq_d   = '0;
               end else begin
                  wr_en = (i_wrData != CHAR_W'(CHAR_LF));
                  if ((i_wrData == CHAR_W'(CHAR_LF)) || (col_q == COL_LAST)) begin
                     col_d = '0;
                     if (row_q == ROW_LAST) begin
                        state_d = ST_SCROLL;
                        seq_d   = '0;
                     end else begin
                        row_d = row_q + ROW_W'(1);
                     end
                  end else begin
                     col_d = col_q + COL_W'(1);
                  end
               end
            end
         end
         ST_SCROLL: begin
            // Copy each cell from one row below, then blank the last row.
            wr_en   = 1'b1;
            wr_addr = seq_q;
            wr_data = (seq_q < ADDR_W'(COPY_N)) ? src_data : CHAR_W'(CHAR_SPACE);
            if (seq_q == SEQ_LAST) state_d = ST_IDLE;
            else                   seq_d   = seq_q + ADDR_W'(1);
         end
         default: begin
            wr_en   = 1'b1;
            wr_addr = seq_q;
            wr_data = CHAR_W'(CHAR_SPACE);
            if (seq_q == SEQ_LAST) begin
               state_d = ST_IDLE;
               row_d   = '0;
               col_d   = '0;
            end else begin
               seq_d = seq_q + ADDR_W'(1);
            end
         end
      endcase

      // Reset wins over any write, including an in-flight scroll/clear.
      if (i_rst) wr_en = 1'b0;
   end

   // State and cursor registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (i_rst) begin
         state_q <= ST_IDLE;
         row_q   <= '0;
         col_q   <= '0;
         seq_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         seq_q   <= seq_d;
      end
   end

   text_buffer_ram #(
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .CHAR_W   (CHAR_W),
      .INIT_BASE(INIT_BASE)
   ) u_ram (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_wr_en   (wr_en),
      .i_wr_addr (wr_addr),
      .i_wr_data (wr_data),
      .i_rd_en   (rd_en),
      .i_rd_addr (rd_addr),
      .o_rd_data (o_rdData),
      .i_src_addr(src_addr),
      .o_src_data(src_data)
   );

   assign o_busy      = (state_q != ST_IDLE);
   assign o_wrReady   = (state_q == ST_IDLE);
   assign o_cursorRow = row_q;
   assign o_cursorCol = col_q;

endmodule

// File: tb/tb_text_buffer.sv
// Directed self-checking bench for text_buffer (COLS=16, ROWS=2, INIT_BASE=48).
module tb_text_buffer;

   logic       clk;
   logic       i_rst;
   logic       i_wrValid;
   logic       o_wrReady;
   logic [7:0] i_wrData;
   logic       i_rdRow;
   logic [3:0] i_rdCol;
   logic [7:0] o_rdData;
   logic       o_cursorRow;
   logic [3:0] o_cursorCol;
   logic       o_busy;

   int checks = 0;
   int errors = 0;

   logic [7:0]  exp_mem [32];
   logic [31:0] sb [$];

   text_buffer #(.COLS(16), .ROWS(2), .CHAR_W(8), .INIT_BASE(48)) dut (
      .i_clk      (clk),
      .i_rst      (i_rst),
      .i_wrValid  (i_wrValid),
      .o_wrReady  (o_wrReady),
      .i_wrData   (i_wrData),
      .i_rdRow    (i_rdRow),
      .i_rdCol    (i_rdCol),
      .o_rdData   (o_rdData),
      .o_cursorRow(o_cursorRow),
      .o_cursorCol(o_cursorCol),
      .o_busy     (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input logic [31:0] obs, input logic [31:0] expv, input string tag);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic read_cell(input int r, input int c, input string tag);
      i_rdRow = 1'(r);
      i_rdCol = 4'(c);
      sb.push_back({24'b0, exp_mem[r * 16 + c]});
      tick();
      check({24'b0, o_rdData}, sb.pop_front(), $sformatf("%s(%0d,%0d)", tag, r, c));
   endtask

   task automatic check_all(input string tag);
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 16; c++)
            read_cell(r, c, tag);
   endtask

   task automatic check_cursor(input int r, input int c, input string tag);
      check({31'b0, o_cursorRow}, 32'(r), {tag, "_row"});
      check({28'b0, o_cursorCol}, 32'(c), {tag, "_col"});
   endtask

   // Present one character and hold it until accepted (bounded wait).
   task automatic send(input logic [7:0] d);
      int n;
      i_wrValid = 1'b1;
      i_wrData  = d;
      n = 0;
      while (!o_wrReady && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) check({31'b0, o_wrReady}, 32'd1, "wr_ready_timeout");
      tick();
      i_wrValid = 1'b0;
   endtask

   initial begin
      int n;
      for (int i = 0; i < 32; i++) exp_mem[i] = 8'(48 + i);
      i_rst = 1'b1; i_wrValid = 1'b0; i_wrData = 8'h00; i_rdRow = 1'b0; i_rdCol = 4'd0;

      // Reset state
      tick();
      i_rst = 1'b0;
      check({31'b0, o_busy}, 32'd0, "rst_busy");
      check({31'b0, o_wrReady}, 32'd1, "rst_ready");
      check({24'b0, o_rdData}, 32'd0, "rst_rddata");
      check_cursor(0, 0, "rst_cursor");

      // Power-on contents
      read_cell(0, 0, "init");
      read_cell(0, 15, "init");
      read_cell(1, 0, "init");

      // Sixteen 'A' fill row 0 and wrap the cursor without scrolling
      for (int i = 0; i < 16; i++) begin
         send(8'h41);
         exp_mem[i] = 8'h41;
         check({31'b0, o_busy}, 32'd0, "fill_row_busy");
      end
      check_cursor(1, 0, "fill_row_cursor");
      for (int c = 0; c < 16; c++) read_cell(0, c, "fill_row");

      // Reset moves cursor only, then 32 characters cause a scroll
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      check_cursor(0, 0, "rst2_cursor");
      read_cell(0, 0, "rst2_keeps_cells");
      for (int i = 0; i < 32; i++) send(8'(8'h41 + i));
      n = 0;
      while (o_busy && n < 100) begin
         n++;
         tick();
      end
      check(32'(n), 32'd32, "scroll_busy_cycles");
      for (int i = 0; i < 16; i++) exp_mem[i] = 8'(8'h51 + i);
      for (int i = 16; i < 32; i++) exp_mem[i] = 8'h20;
      check_cursor(1, 0, "scroll_cursor");
      check_all("scroll");

      // Form feed clears; held write lands on the first ready cycle
      i_wrValid = 1'b1;
      i_wrData  = 8'h0C;
      tick();
      i_wrData  = 8'h42;
      n = 0;
      while (!o_wrReady && n < 100) begin
         tick();
         n++;
      end
      check(32'(n + 1), 32'd33, "clear_accept_latency");
      tick();
      i_wrValid = 1'b0;
      for (int i = 0; i < 32; i++) exp_mem[i] = 8'h20;
      exp_mem[0] = 8'h42;
      check_cursor(0, 1, "clear_cursor");
      check_all("clear");

      // Read-before-write on the same cell
      send(8'h31); exp_mem[1] = 8'h31;
      send(8'h32); exp_mem[2] = 8'h32;
      i_rdRow = 1'b0;
      i_rdCol = 4'd3;
      sb.push_back(32'h20);
      i_wrValid = 1'b1;
      i_wrData  = 8'h5A;
      tick();
      i_wrValid = 1'b0;
      check({24'b0, o_rdData}, sb.pop_front(), "rbw_old");
      exp_mem[3] = 8'h5A;
      sb.push_back(32'h5A);
      tick();
      check({24'b0, o_rdData}, sb.pop_front(), "rbw_new");

      // LF to row 1, fill it, reset five cycles into the scroll
      send(8'h0A);
      check_cursor(1, 0, "lf_cursor");
      check({31'b0, o_busy}, 32'd0, "lf_busy");
      for (int i = 0; i < 16; i++) begin
         send(8'(8'h61 + i));
         exp_mem[16 + i] = 8'(8'h61 + i);
      end
      check({31'b0, o_busy}, 32'd1, "abort_scroll_busy");
      for (int i = 0; i < 5; i++) tick();
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      check({31'b0, o_busy}, 32'd0, "abort_busy");
      check({31'b0, o_wrReady}, 32'd1, "abort_ready");
      check_cursor(0, 0, "abort_cursor");
      for (int i = 0; i < 5; i++) exp_mem[i] = exp_mem[16 + i];
      check_all("abort");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
